// File: rtl/pa_perips_intc_if.sv
// rtl/pa_perips_intc_if.sv - register bus bundle between the data-bus matrix s6 slot and the interrupt controller
interface pa_perips_intc_if;
  logic [7:0]  addr_i;
  logic        data_rd_i;
  logic        data_we_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output addr_i,
    output data_rd_i,
    output data_we_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_rd_i,
    input  data_we_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/pa_perips_intc.sv
// rtl/pa_perips_intc.sv - peripheral interrupt controller with claim/complete; optional PA_INTC_SYNC_EN input synchronizer
module pa_perips_intc #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pa_perips_intc_if.slave    bus,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               irq_o
);

  localparam logic [7:0] ADDR_PENDING = 8'h00;
  localparam logic [7:0] ADDR_ENABLE  = 8'h04;
  localparam logic [7:0] ADDR_TYPE    = 8'h08;
  localparam logic [7:0] ADDR_CLAIM   = 8'h0C;
  localparam logic [7:0] ADDR_INSVC   = 8'h10;

  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] pend_edge_q, pend_edge_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] type_q, type_d;
  logic [NUM_SRC-1:0] insvc_q, insvc_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] cmpl_vec;
  logic [4:0]         claim_id;
  logic               claim_hit;
  logic               claim_sel;
  logic [31:0]        rdata;

`ifdef PA_INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync1_d;
  logic [NUM_SRC-1:0] sync2_q, sync2_d;

  // two-flop synchronizer for sources outside the clk_i domain
  always_comb begin
    sync1_d = src_i;
    sync2_d = sync1_q;
    src_in  = sync2_q;
  end

  // synchronizer stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  // sources are already synchronous to clk_i
  always_comb begin
    src_in = src_i;
  end
`endif

  // pending view, priority claim id and next-state for all controller state
  always_comb begin
    claim_sel = (bus.addr_i == ADDR_CLAIM);
    pending   = (type_q & pend_edge_q) | (~type_q & src_q);
    active    = pending & enable_q & ~insvc_q;
    edge_det  = src_in & ~src_q;

    // scan from the top so the lowest active index wins
    claim_id = 5'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (active[k]) claim_id = 5'(k + 1);
    end
    claim_hit = bus.data_rd_i && claim_sel && (claim_id != 5'd0);

    claim_vec = '0;
    cmpl_vec  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      claim_vec[k] = claim_hit && (claim_id == 5'(k + 1));
      cmpl_vec[k]  = bus.data_we_i && claim_sel && (bus.data_i[4:0] == 5'(k + 1)) && insvc_q[k];
    end

    // a new edge beats a claim-clear; gating by type_q drops the latch whenever the
    // source is (or just was) level-type, so a switch to edge starts clean
    pend_edge_d = ((pend_edge_q & ~claim_vec) | edge_det) & type_q;
    // claim only picks sources not in service, complete only retires ones in service,
    // so the two vectors never overlap
    insvc_d     = (insvc_q | claim_vec) & ~cmpl_vec;
    enable_d    = (bus.data_we_i && bus.addr_i == ADDR_ENABLE) ? bus.data_i[NUM_SRC-1:0] : enable_q;
    type_d      = (bus.data_we_i && bus.addr_i == ADDR_TYPE)   ? bus.data_i[NUM_SRC-1:0] : type_q;
    src_d       = src_in;
    irq_d       = |active;
  end

  // controller state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q       <= '0;
      pend_edge_q <= '0;
      enable_q    <= '0;
      type_q      <= '0;
      insvc_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      src_q       <= src_d;
      pend_edge_q <= pend_edge_d;
      enable_q    <= enable_d;
      type_q      <= type_d;
      insvc_q     <= insvc_d;
      irq_q       <= irq_d;
    end
  end

  // zero-wait read mux, forced to zero outside a read and during reset
  always_comb begin
    rdata = 32'd0;
    case (bus.addr_i)
      ADDR_PENDING: rdata = 32'(pending);
      ADDR_ENABLE:  rdata = 32'(enable_q);
      ADDR_TYPE:    rdata = 32'(type_q);
      ADDR_CLAIM:   rdata = 32'(claim_id);
      ADDR_INSVC:   rdata = 32'(insvc_q);
      default:      rdata = 32'd0;
    endcase
    bus.data_o = (bus.data_rd_i && !rst_i) ? rdata : 32'd0;
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_pa_perips_intc.sv
// tb/tb_pa_perips_intc.sv - self-checking bench for pa_perips_intc with a per-source behavioural model
module tb_pa_perips_intc;
  localparam int N = 8;
`ifdef PA_INTC_SYNC_EN
  localparam bit SYNC    = 1'b1;
  localparam int EXP_LAT = 4;
`else
  localparam bit SYNC    = 1'b0;
  localparam int EXP_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src;
  logic         irq;
  bit           run = 1'b0;
  int           checks = 0;
  int           failures = 0;

  pa_perips_intc_if bus_if ();

  pa_perips_intc #(.NUM_SRC(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave),
    .src_i (src),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // model: one record per source, stepped with the rules of the register map
  bit m_pe[N];
  bit m_en[N];
  bit m_ty[N];
  bit m_ins[N];
  bit m_sq[N];
  bit m_p1[N];
  bit m_p2[N];
  bit m_irq;

  function automatic bit m_pending(input int k);
    return m_ty[k] ? m_pe[k] : m_sq[k];
  endfunction

  function automatic int m_claim();
    for (int k = 0; k < N; k++)
      if (m_pending(k) && m_en[k] && !m_ins[k]) return k + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < N; k++) begin
      case (a)
        8'h00: r[k] = m_pending(k);
        8'h04: r[k] = m_en[k];
        8'h08: r[k] = m_ty[k];
        8'h10: r[k] = m_ins[k];
        default: ;
      endcase
    end
    if (a == 8'h0C) r = 32'(m_claim());
    return r;
  endfunction

  always @(posedge clk) begin
    int cid;
    int id;
    bit s_in[N];
    bit do_claim;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_pe[k] = 0; m_en[k] = 0; m_ty[k] = 0; m_ins[k] = 0;
        m_sq[k] = 0; m_p1[k] = 0; m_p2[k] = 0;
      end
      m_irq = 0;
    end else begin
      cid = m_claim();
      for (int k = 0; k < N; k++) s_in[k] = SYNC ? m_p2[k] : src[k];
      do_claim = bus_if.data_rd_i && bus_if.addr_i == 8'h0C && cid != 0;
      for (int k = 0; k < N; k++) begin
        if (do_claim && cid == k + 1) m_pe[k] = 0;
        if (m_ty[k] && s_in[k] && !m_sq[k]) m_pe[k] = 1;
      end
      if (bus_if.data_we_i && bus_if.addr_i == 8'h0C) begin
        id = int'(bus_if.data_i[4:0]);
        if (id >= 1 && id <= N && m_ins[id-1]) m_ins[id-1] = 0;
      end
      if (do_claim) m_ins[cid-1] = 1;
      if (bus_if.data_we_i && bus_if.addr_i == 8'h04)
        for (int k = 0; k < N; k++) m_en[k] = bus_if.data_i[k];
      if (bus_if.data_we_i && bus_if.addr_i == 8'h08)
        for (int k = 0; k < N; k++) begin
          if (m_ty[k] != bus_if.data_i[k]) m_pe[k] = 0;
          m_ty[k] = bus_if.data_i[k];
        end
      for (int k = 0; k < N; k++) begin
        m_p2[k] = m_p1[k];
        m_p1[k] = src[k];
        m_sq[k] = s_in[k];
      end
      m_irq = (cid != 0);
    end
  end

  // every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (run) begin
      chk("irq_o", 32'(irq), 32'(m_irq));
      chk("data_o", bus_if.data_o, (bus_if.data_rd_i && !rst) ? m_read(bus_if.addr_i) : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_if.addr_i    = a;
    bus_if.data_i    = d;
    bus_if.data_we_i = 1'b1;
    cyc();
    bus_if.data_we_i = 1'b0;
    bus_if.data_i    = 32'd0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    bus_if.addr_i    = a;
    bus_if.data_rd_i = 1'b1;
    @(negedge clk);
    chk(name, bus_if.data_o, exp);
    cyc();
    bus_if.data_rd_i = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    src = '0;
    bus_if.addr_i    = 8'h00;
    bus_if.data_rd_i = 1'b0;
    bus_if.data_we_i = 1'b0;
    bus_if.data_i    = 32'd0;

    // reset
    cyc();
    run = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_irq", 32'(irq), 32'd0);
    for (int a = 0; a <= 16; a += 4) rd(8'(a), 32'd0, "rst_read");

    // edge source, claim, complete
    wr(8'h04, 32'h1);
    wr(8'h08, 32'h1);
    src[0] = 1'b1;
    cyc();
    src[0] = 1'b0;
    chk("s2_irq_n1", 32'(irq), 32'd0);
    rd(8'h00, 32'h1, "s2_pend");
    chk("s2_irq_n2", 32'(irq), 32'd1);
    rd(8'h0C, 32'd1, "s2_claim");
    rd(8'h00, 32'h0, "s2_pend_clr");
    chk("s2_irq_low", 32'(irq), 32'd0);
    rd(8'h10, 32'h1, "s2_insvc");
    wr(8'h0C, 32'd1);
    rd(8'h10, 32'h0, "s2_insvc_clr");

    // level sources, priority, complete while still asserted
    wr(8'h08, 32'h0);
    wr(8'h04, 32'h6);
    src = 8'b0000_0110;
    cyc();
    rd(8'h0C, 32'd2, "s3_claim2");
    rd(8'h0C, 32'd3, "s3_claim3");
    wr(8'h0C, 32'd2);
    chk("s3_irq_low", 32'(irq), 32'd0);
    cyc();
    chk("s3_reassert", 32'(irq), 32'd1);
    src = '0;
    wr(8'h0C, 32'd2);
    wr(8'h0C, 32'd3);
    cyc();

    // edge arriving in the claim cycle survives the claim
    wr(8'h08, 32'h1);
    wr(8'h04, 32'h1);
    src[0] = 1'b1;
    cyc();
    src[0] = 1'b0;
    cyc();
    src[0] = 1'b1;
    rd(8'h0C, 32'd1, "s4_claim");
    rd(8'h00, 32'h1, "s4_pend_kept");
    wr(8'h0C, 32'd1);
    cyc();
    chk("s4_irq", 32'(irq), 32'd1);
    src[0] = 1'b0;
    rd(8'h0C, 32'd1, "s4_claim2");
    wr(8'h0C, 32'd1);

    // ignored completes and unmapped accesses
    wr(8'h0C, 32'd5);
    wr(8'h0C, 32'd0);
    wr(8'h20, 32'hFFFF_FFFF);
    rd(8'h10, 32'h0, "s5_insvc");
    rd(8'h00, 32'h0, "s5_pend");
    rd(8'h20, 32'h0, "s5_unmapped");
    rd(8'h04, 32'h1, "s5_en");

    // type changes, disable while pending, write width
    src[0] = 1'b1;
    cyc();
    src[0] = 1'b0;
    cyc();
    rd(8'h00, 32'h1, "s7_pend_edge");
    wr(8'h08, 32'h0);
    rd(8'h00, 32'h0, "s7_pend_lvl");
    src[0] = 1'b1;
    cyc();
    cyc();
    wr(8'h08, 32'h1);
    rd(8'h00, 32'h0, "s7_pend_l2e");
    src[0] = 1'b0;
    cyc();
    src[0] = 1'b1;
    cyc();
    src[0] = 1'b0;
    cyc();
    cyc();
    chk("s7_irq_on", 32'(irq), 32'd1);
    wr(8'h04, 32'h0);
    cyc();
    chk("s7_irq_dis", 32'(irq), 32'd0);
    rd(8'h00, 32'h1, "s7_pend_kept");
    wr(8'h04, 32'hFFFF_FFFF);
    rd(8'h04, 32'hFF, "s7_en_width");
    wr(8'h08, 32'hFFFF_FF00);
    rd(8'h08, 32'h0, "s7_type_width");

    // reset during a claim read
    wr(8'h08, 32'h1);
    wr(8'h04, 32'h1);
    src[0] = 1'b1;
    cyc();
    src[0] = 1'b0;
    cyc();
    rst = 1'b1;
    rd(8'h0C, 32'd0, "s8_claim_rst");
    rst = 1'b0;
    rd(8'h10, 32'h0, "s8_insvc");
    rd(8'h04, 32'h0, "s8_en");
    chk("s8_irq", 32'(irq), 32'd0);

    // source-to-irq latency
    wr(8'h04, 32'h1);
    wr(8'h08, 32'h1);
    src[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (irq && lat == 0) lat = i;
    end
    src[0] = 1'b0;
    chk("s6_latency", 32'(lat), 32'(EXP_LAT));
    cyc();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
